axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares the single AXI read address/data channel of the core tile among NUM_REQ read requesters: icache refill, dcache miss-read and dcache uncached read.
- Grants AR requests round-robin, with a per-requester outstanding limit.
- Stamps each AR with the requester index as its AXI ID.
- Routes R beats back by ID. Each requester's tags are kept in a per-requester FIFO, since AXI keeps same-ID responses in order.
- Sits between the cache memory interfaces and the atomics/AXI upstream path.

Parameters:
- NUM_REQ, 3, number of read requesters (index 0 highest priority after reset)
- ADDR_WIDTH, 64, AXI address width
- DATA_WIDTH, 128, AXI R data width
- ID_WIDTH, 4, AXI ID width; must satisfy 2**ID_WIDTH >= NUM_REQ
- TAG_WIDTH, 4, requester-private transaction tag width
- MAX_OUTSTANDING, 4, per-requester limit on in-flight bursts (power of 2)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  request valid, one per requester
- req_ready_o  out  NUM_REQ  request accepted this cycle
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  burst start address, requester i at slice i
- req_len_i  in  NUM_REQ*8  AXI len (beats-1)
- req_tag_i  in  NUM_REQ*TAG_WIDTH  tag returned with response beats
- ar_valid_o  out  1  AR valid
- ar_ready_i  in  1  AR ready
- ar_addr_o  out  ADDR_WIDTH  AR address
- ar_len_o  out  8  AR len
- ar_id_o  out  ID_WIDTH  granted requester index
- ar_size_o  out  3  constant log2(DATA_WIDTH/8)
- ar_burst_o  out  2  constant 2'b01 (INCR)
- r_valid_i  in  1  R valid
- r_ready_o  out  1  R ready
- r_data_i  in  DATA_WIDTH  R data
- r_id_i  in  ID_WIDTH  R id
- r_resp_i  in  2  R resp
- r_last_i  in  1  R last
- rsp_valid_o  out  NUM_REQ  response beat valid for requester i
- rsp_ready_i  in  NUM_REQ  requester i ready
- rsp_data_o  out  DATA_WIDTH  shared response data (= r_data_i)
- rsp_tag_o  out  TAG_WIDTH  head tag of FIFO[r_id_i]
- rsp_last_o  out  1  = r_last_i
- rsp_err_o  out  1  r_resp_i[1] (SLVERR/DECERR)
- unexp_rsp_o  out  1  sticky: R beat for an ID with no outstanding burst

Behaviour:
- Reset (async, rstn_i low):
  - ar_valid_o=0, req_ready_o=0, unexp_rsp_o=0.
  - All outstanding counters 0, all tag FIFOs empty, round-robin pointer =0.
- Eligibility: requester i is eligible when req_valid_i[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- AR stage:
  - One output register. It loads when (!ar_valid_o || ar_ready_i).
  - On load, it selects the first eligible requester starting at the pointer and wrapping modulo NUM_REQ.
  - req_ready_o[winner]=1 that cycle only; at most one req_ready_o bit is high.
- Pointer update: on acceptance, pointer = winner+1 (wrap to 0 at NUM_REQ).
- AR register contents:
  - ar_addr/len come from the winner's slices; ar_id_o = winner.
  - ar_valid_o rises the cycle after acceptance (latency 1).
  - Throughput is 1 AR/cycle while ar_ready_i=1.
  - AR fields are stable while ar_valid_o=1 && !ar_ready_i.
- No eligible requester while the register loads: ar_valid_o goes 0.
- On acceptance of requester i:
  - outstanding[i] increments.
  - req_tag_i[i] is pushed to FIFO[i] (depth MAX_OUTSTANDING; it cannot overflow because of the eligibility rule).
- R routing is combinational, with no added latency:
  - id = r_id_i. If id < NUM_REQ and outstanding[id] > 0: rsp_valid_o[id]=r_valid_i, other bits 0, r_ready_o=rsp_ready_i[id].
  - Otherwise (unexpected): rsp_valid_o=0 and r_ready_o=1, so the beat is dropped. unexp_rsp_o sets on handshake and stays set until reset.
- On an R handshake with r_last_i=1 for a valid id: FIFO[id] pops and outstanding[id] decrements.
- Simultaneous acceptance and last-beat completion on the same requester:
  - Counter is unchanged.
  - FIFO push and pop both occur. The popped tag is the old head; when the FIFO was empty it cannot be popped, because outstanding>0 is required for routing.
- Requesters may drop req_valid_i without acceptance; the block must not rely on request stability.

Test Plan:
- Reset, then req_valid_i=3'b001, addr=0x8000_0040, len=3, tag=5, ar_ready=1 -> req_ready_o=001 at cycle N; AR at N+1 with id=0, len=3, size=4, burst=01. R beats id=0 ×4 -> rsp_valid_o=001 each beat, rsp_tag_o=5, rsp_last_o on the 4th; outstanding[0] returns to 0.
- All three requesters valid every cycle, ar_ready=1 -> grant order 0,1,2,0,1,2; AR ids match that order.
- Requester 1 issues 4 bursts with no R returned -> 5th request is not accepted (req_ready_o[1]=0) while requesters 0 and 2 keep being granted. After one last beat for id=1, the 5th is accepted the following cycle.
- ar_ready_i held 0 for 3 cycles with ar_valid_o=1 -> AR fields are stable and req_ready_o=0 throughout; ar_ready_i=1 -> next winner is loaded the same cycle.
- R beat with id=2 while outstanding[2]=0, and separately r_resp=2'b10 on a valid id -> first: r_ready_o=1, rsp_valid_o=0, unexp_rsp_o=1 and sticky. Second: rsp_err_o=1 with normal routing.
- Assert rstn_i mid-burst (outstanding[0]=2) -> ar_valid_o=0, counters 0, and pointer 0 immediately. After release, requester 0 wins first.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin AXI read arbiter: shares one AR/R channel among NUM_REQ requesters, routes R beats back by ID.
// Latency: AR registered (1 cycle after acceptance); R routing combinational (0 cycles).
// Backpressure: AR register reloads only when empty or ar_ready_i; R stalls on the addressed requester, unexpected beats are sunk.
module axi_read_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 128,
    parameter int ID_WIDTH        = 4,
    parameter int TAG_WIDTH       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*8-1:0]            req_len_i,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag_i,
    output logic                            ar_valid_o,
    input  logic                            ar_ready_i,
    output logic [ADDR_WIDTH-1:0]           ar_addr_o,
    output logic [7:0]                      ar_len_o,
    output logic [ID_WIDTH-1:0]             ar_id_o,
    output logic [2:0]                      ar_size_o,
    output logic [1:0]                      ar_burst_o,
    input  logic                            r_valid_i,
    output logic                            r_ready_o,
    input  logic [DATA_WIDTH-1:0]           r_data_i,
    input  logic [ID_WIDTH-1:0]             r_id_i,
    input  logic [1:0]                      r_resp_i,
    input  logic                            r_last_i,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    input  logic [NUM_REQ-1:0]              rsp_ready_i,
    output logic [DATA_WIDTH-1:0]           rsp_data_o,
    output logic [TAG_WIDTH-1:0]            rsp_tag_o,
    output logic                            rsp_last_o,
    output logic                            rsp_err_o,
    output logic                            unexp_rsp_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int FP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [ID_WIDTH-1:0]   id;
    } ar_t;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    logic                 ar_vld;
    ar_t                  ar_q;
    ar_t                  ar_d;
    logic                 ar_load;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   busy;
    logic [NUM_REQ-1:0]   id_sel;
    logic [NUM_REQ-1:0]   push;
    logic [NUM_REQ-1:0]   pop;
    logic                 rsp_hit;
    logic                 sel_rdy;
    logic                 r_hs;
    logic                 unexp_q;
    logic [CNT_W-1:0]     outstanding [NUM_REQ];
    logic [FP_W-1:0]      wr_ptr [NUM_REQ];
    logic [FP_W-1:0]      rd_ptr [NUM_REQ];
    logic [TAG_WIDTH-1:0] tag_mem [NUM_REQ][MAX_OUTSTANDING];
    logic                 unused_resp;

    assign unused_resp = r_resp_i[0];

    always_comb begin
        eligible = '0;
        busy     = '0;
        id_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (outstanding[i] < CNT_W'(MAX_OUTSTANDING));
            busy[i]     = (outstanding[i] != '0);
            id_sel[i]   = (r_id_i == ID_WIDTH'(i));
        end
    end

    // Scan from the far end so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[wrap_add(rr_ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    // Held in reset, nothing may be accepted even though the AR register reads empty.
    assign ar_load = rstn_i && (!ar_vld || ar_ready_i);

    always_comb begin
        req_ready_o = '0;
        if (ar_load && win_found) req_ready_o[win_idx] = 1'b1;
        ar_d.addr = req_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        ar_d.len  = req_len_i[win_idx*8 +: 8];
        ar_d.id   = ID_WIDTH'(win_idx);
    end

    assign push = req_ready_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ar_vld <= 1'b0;
            ar_q   <= '0;
            rr_ptr <= '0;
        end else if (ar_load) begin
            ar_vld <= win_found;
            if (win_found) begin
                ar_q   <= ar_d;
                rr_ptr <= wrap_add(win_idx, 1);
            end
        end
    end

    always_comb begin
        rsp_hit     = 1'b0;
        sel_rdy     = 1'b0;
        rsp_tag_o   = '0;
        rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id_sel[i] && busy[i]) begin
                rsp_hit        = 1'b1;
                sel_rdy        = rsp_ready_i[i];
                rsp_valid_o[i] = r_valid_i;
                rsp_tag_o      = tag_mem[i][rd_ptr[i]];
            end
        end
    end

    assign r_ready_o = rsp_hit ? sel_rdy : 1'b1;
    assign r_hs      = r_valid_i && r_ready_o;
    assign pop       = rsp_valid_o & {NUM_REQ{r_hs && r_last_i}};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i] <= '0;
                wr_ptr[i]      <= '0;
                rd_ptr[i]      <= '0;
            end
            unexp_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i] && !pop[i])      outstanding[i] <= outstanding[i] + 1'b1;
                else if (pop[i] && !push[i]) outstanding[i] <= outstanding[i] - 1'b1;
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
            if (r_hs && !rsp_hit) unexp_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) tag_mem[i][wr_ptr[i]] <= req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    assign ar_valid_o  = ar_vld;
    assign ar_addr_o   = ar_q.addr;
    assign ar_len_o    = ar_q.len;
    assign ar_id_o     = ar_q.id;
    assign ar_size_o   = 3'($clog2(DATA_WIDTH / 8));
    assign ar_burst_o  = 2'b01;
    assign rsp_data_o  = r_data_i;
    assign rsp_last_o  = r_last_i;
    assign rsp_err_o   = r_resp_i[1];
    assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: each task drives one scenario and checks against hand-computed values.
module tb_axi_read_arbiter;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [2:0]   req_valid_i;
    logic [2:0]   req_ready_o;
    logic [191:0] req_addr_i;
    logic [23:0]  req_len_i;
    logic [11:0]  req_tag_i;
    logic         ar_valid_o;
    logic         ar_ready_i;
    logic [63:0]  ar_addr_o;
    logic [7:0]   ar_len_o;
    logic [3:0]   ar_id_o;
    logic [2:0]   ar_size_o;
    logic [1:0]   ar_burst_o;
    logic         r_valid_i;
    logic         r_ready_o;
    logic [127:0] r_data_i;
    logic [3:0]   r_id_i;
    logic [1:0]   r_resp_i;
    logic         r_last_i;
    logic [2:0]   rsp_valid_o;
    logic [2:0]   rsp_ready_i;
    logic [127:0] rsp_data_o;
    logic [3:0]   rsp_tag_o;
    logic         rsp_last_o;
    logic         rsp_err_o;
    logic         unexp_rsp_o;

    int n_chk = 0;
    int n_pass = 0;

    axi_read_arbiter dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_tag_i(req_tag_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_len_o(ar_len_o), .ar_id_o(ar_id_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_id_i(r_id_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_tag_o(rsp_tag_o), .rsp_last_o(rsp_last_o), .rsp_err_o(rsp_err_o),
        .unexp_rsp_o(unexp_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i = '0; req_addr_i = '0; req_len_i = '0; req_tag_i = '0;
        ar_ready_i = 1'b1;
        r_valid_i = 1'b0; r_data_i = '0; r_id_i = '0; r_resp_i = '0; r_last_i = 1'b0;
        rsp_ready_i = '0;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        clear_inputs();
        step();
        step();
        rstn_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn_i = 1'b0;
        req_valid_i = 3'b111;
        #1;
        n_chk++; if (ar_valid_o !== 1'b0) $display("FAIL reset_ar_valid got=%b exp=0", ar_valid_o); else n_pass++;
        n_chk++; if (req_ready_o !== 3'b000) $display("FAIL reset_req_ready got=%b exp=000", req_ready_o); else n_pass++;
        step();
        n_chk++; if (unexp_rsp_o !== 1'b0) $display("FAIL reset_unexp got=%b exp=0", unexp_rsp_o); else n_pass++;
        n_chk++; if (rsp_valid_o !== 3'b000) $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid_o); else n_pass++;
        req_valid_i = '0;
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req_valid_i = 3'b001;
        req_addr_i[63:0] = 64'h8000_0040;
        req_len_i[7:0] = 8'd3;
        req_tag_i[3:0] = 4'd5;
        #1;
        n_chk++; if (req_ready_o !== 3'b001) $display("FAIL single_req_ready got=%b exp=001", req_ready_o); else n_pass++;
        step();
        req_valid_i = '0;
        n_chk++; if (ar_valid_o !== 1'b1) $display("FAIL single_ar_valid got=%b exp=1", ar_valid_o); else n_pass++;
        n_chk++; if (ar_addr_o !== 64'h8000_0040) $display("FAIL single_ar_addr got=%h exp=80000040", ar_addr_o); else n_pass++;
        n_chk++; if (ar_id_o !== 4'd0) $display("FAIL single_ar_id got=%0d exp=0", ar_id_o); else n_pass++;
        n_chk++; if (ar_len_o !== 8'd3) $display("FAIL single_ar_len got=%0d exp=3", ar_len_o); else n_pass++;
        n_chk++; if (ar_size_o !== 3'd4) $display("FAIL single_ar_size got=%0d exp=4", ar_size_o); else n_pass++;
        n_chk++; if (ar_burst_o !== 2'b01) $display("FAIL single_ar_burst got=%b exp=01", ar_burst_o); else n_pass++;
        step();
        n_chk++; if (ar_valid_o !== 1'b0) $display("FAIL single_ar_idle got=%b exp=0", ar_valid_o); else n_pass++;
        rsp_ready_i = 3'b111;
        r_id_i = 4'd0;
        for (int b = 0; b < 4; b++) begin
            r_valid_i = 1'b1;
            r_data_i = {32'hA5A5_0000 + 32'(b), 96'h0};
            r_last_i = (b == 3);
            #1;
            n_chk++; if (rsp_valid_o !== 3'b001) $display("FAIL single_rsp_valid beat=%0d got=%b exp=001", b, rsp_valid_o); else n_pass++;
            n_chk++; if (rsp_tag_o !== 4'd5) $display("FAIL single_rsp_tag beat=%0d got=%0d exp=5", b, rsp_tag_o); else n_pass++;
            n_chk++; if (rsp_last_o !== (b == 3)) $display("FAIL single_rsp_last beat=%0d got=%b exp=%b", b, rsp_last_o, (b == 3)); else n_pass++;
            n_chk++; if (rsp_data_o !== {32'hA5A5_0000 + 32'(b), 96'h0}) $display("FAIL single_rsp_data beat=%0d got=%h", b, rsp_data_o); else n_pass++;
            step();
        end
        r_valid_i = 1'b0; r_last_i = 1'b0;
        // With nothing outstanding for id 0 the beat must be treated as unexpected.
        rsp_ready_i = 3'b000;
        r_valid_i = 1'b1;
        #1;
        n_chk++; if (rsp_valid_o !== 3'b000) $display("FAIL single_drained_rsp_valid got=%b exp=000", rsp_valid_o); else n_pass++;
        n_chk++; if (r_ready_o !== 1'b1) $display("FAIL single_drained_r_ready got=%b exp=1", r_ready_o); else n_pass++;
        r_valid_i = 1'b0;
        #1;
    endtask

    task automatic test_round_robin();
        logic [2:0] e;
        do_reset();
        req_valid_i = 3'b111;
        #1;
        for (int k = 0; k < 6; k++) begin
            e = 3'b001 << (k % 3);
            n_chk++; if (req_ready_o !== e) $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready_o, e); else n_pass++;
            step();
            n_chk++; if (ar_id_o !== 4'(k % 3)) $display("FAIL rr_ar_id k=%0d got=%0d exp=%0d", k, ar_id_o, k % 3); else n_pass++;
        end
        req_valid_i = '0;
        step();
    endtask

    task automatic test_limit();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b100; exp_seq[1] = 3'b001; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
        do_reset();
        req_valid_i = 3'b010;
        for (int k = 0; k < 4; k++) begin
            req_tag_i[7:4] = 4'(k + 1);
            #1;
            n_chk++; if (req_ready_o !== 3'b010) $display("FAIL limit_fill k=%0d got=%b exp=010", k, req_ready_o); else n_pass++;
            step();
        end
        req_valid_i = 3'b111;
        req_tag_i[7:4] = 4'd9;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (req_ready_o !== exp_seq[k]) $display("FAIL limit_others k=%0d got=%b exp=%b", k, req_ready_o, exp_seq[k]); else n_pass++;
            step();
        end
        req_valid_i = 3'b010;
        r_valid_i = 1'b1; r_id_i = 4'd1; r_last_i = 1'b1; rsp_ready_i = 3'b010;
        #1;
        n_chk++; if (req_ready_o !== 3'b000) $display("FAIL limit_full got=%b exp=000", req_ready_o); else n_pass++;
        n_chk++; if (rsp_valid_o !== 3'b010) $display("FAIL limit_rsp_valid got=%b exp=010", rsp_valid_o); else n_pass++;
        n_chk++; if (rsp_tag_o !== 4'd1) $display("FAIL limit_head_tag got=%0d exp=1", rsp_tag_o); else n_pass++;
        step();
        r_valid_i = 1'b0; r_last_i = 1'b0;
        #1;
        n_chk++; if (req_ready_o !== 3'b010) $display("FAIL limit_reopen got=%b exp=010", req_ready_o); else n_pass++;
        step();
        req_valid_i = '0;
        step();
    endtask

    task automatic test_stall();
        do_reset();
        req_valid_i = 3'b001;
        req_addr_i[63:0] = 64'h1000;
        req_len_i[7:0] = 8'd2;
        #1;
        step();
        ar_ready_i = 1'b0;
        req_valid_i = 3'b010;
        req_addr_i[127:64] = 64'h2000;
        req_len_i[15:8] = 8'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_chk++; if (req_ready_o !== 3'b000) $display("FAIL stall_req_ready c=%0d got=%b exp=000", c, req_ready_o); else n_pass++;
            n_chk++; if (ar_valid_o !== 1'b1) $display("FAIL stall_ar_valid c=%0d got=%b exp=1", c, ar_valid_o); else n_pass++;
            n_chk++; if (ar_addr_o !== 64'h1000 || ar_len_o !== 8'd2 || ar_id_o !== 4'd0)
                $display("FAIL stall_fields c=%0d got=%h/%0d/%0d exp=1000/2/0", c, ar_addr_o, ar_len_o, ar_id_o); else n_pass++;
            step();
        end
        ar_ready_i = 1'b1;
        #1;
        n_chk++; if (req_ready_o !== 3'b010) $display("FAIL stall_release got=%b exp=010", req_ready_o); else n_pass++;
        step();
        req_valid_i = '0;
        n_chk++; if (ar_valid_o !== 1'b1 || ar_id_o !== 4'd1 || ar_addr_o !== 64'h2000 || ar_len_o !== 8'd7)
            $display("FAIL stall_next_ar got=%b/%0d/%h/%0d exp=1/1/2000/7", ar_valid_o, ar_id_o, ar_addr_o, ar_len_o); else n_pass++;
        step();
    endtask

    task automatic test_unexpected();
        do_reset();
        r_valid_i = 1'b1; r_id_i = 4'd2; r_last_i = 1'b1; rsp_ready_i = 3'b000;
        #1;
        n_chk++; if (r_ready_o !== 1'b1) $display("FAIL unexp_r_ready got=%b exp=1", r_ready_o); else n_pass++;
        n_chk++; if (rsp_valid_o !== 3'b000) $display("FAIL unexp_rsp_valid got=%b exp=000", rsp_valid_o); else n_pass++;
        n_chk++; if (unexp_rsp_o !== 1'b0) $display("FAIL unexp_before_edge got=%b exp=0", unexp_rsp_o); else n_pass++;
        step();
        r_valid_i = 1'b0;
        n_chk++; if (unexp_rsp_o !== 1'b1) $display("FAIL unexp_set got=%b exp=1", unexp_rsp_o); else n_pass++;
        step();
        n_chk++; if (unexp_rsp_o !== 1'b1) $display("FAIL unexp_sticky got=%b exp=1", unexp_rsp_o); else n_pass++;
        req_valid_i = 3'b100;
        req_tag_i[11:8] = 4'd9;
        #1;
        step();
        req_valid_i = '0;
        step();
        r_valid_i = 1'b1; r_id_i = 4'd2; r_resp_i = 2'b10; r_last_i = 1'b1; rsp_ready_i = 3'b100;
        #1;
        n_chk++; if (rsp_valid_o !== 3'b100) $display("FAIL err_rsp_valid got=%b exp=100", rsp_valid_o); else n_pass++;
        n_chk++; if (rsp_err_o !== 1'b1) $display("FAIL err_flag got=%b exp=1", rsp_err_o); else n_pass++;
        n_chk++; if (rsp_tag_o !== 4'd9) $display("FAIL err_tag got=%0d exp=9", rsp_tag_o); else n_pass++;
        step();
        r_valid_i = 1'b0; r_resp_i = 2'b00; r_last_i = 1'b0;
        n_chk++; if (unexp_rsp_o !== 1'b1) $display("FAIL unexp_still_set got=%b exp=1", unexp_rsp_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid_i = 3'b001;
        req_tag_i[3:0] = 4'd3;
        #1;
        step();
        req_tag_i[3:0] = 4'd4;
        r_valid_i = 1'b1; r_id_i = 4'd0; r_last_i = 1'b1; rsp_ready_i = 3'b001;
        #1;
        n_chk++; if (req_ready_o !== 3'b001) $display("FAIL b2b_accept got=%b exp=001", req_ready_o); else n_pass++;
        n_chk++; if (rsp_tag_o !== 4'd3) $display("FAIL b2b_old_head got=%0d exp=3", rsp_tag_o); else n_pass++;
        step();
        req_valid_i = '0;
        #1;
        n_chk++; if (rsp_valid_o !== 3'b001) $display("FAIL b2b_still_busy got=%b exp=001", rsp_valid_o); else n_pass++;
        n_chk++; if (rsp_tag_o !== 4'd4) $display("FAIL b2b_new_head got=%0d exp=4", rsp_tag_o); else n_pass++;
        step();
        rsp_ready_i = 3'b000;
        #1;
        n_chk++; if (rsp_valid_o !== 3'b000) $display("FAIL b2b_drained got=%b exp=000", rsp_valid_o); else n_pass++;
        r_valid_i = 1'b0; r_last_i = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid_i = 3'b001;
        #1;
        step();
        step();
        rstn_i = 1'b0;
        req_valid_i = '0;
        #1;
        n_chk++; if (ar_valid_o !== 1'b0) $display("FAIL midrst_ar_valid got=%b exp=0", ar_valid_o); else n_pass++;
        n_chk++; if (req_ready_o !== 3'b000) $display("FAIL midrst_req_ready got=%b exp=000", req_ready_o); else n_pass++;
        r_valid_i = 1'b1; r_id_i = 4'd0; rsp_ready_i = 3'b000;
        #1;
        n_chk++; if (rsp_valid_o !== 3'b000 || r_ready_o !== 1'b1)
            $display("FAIL midrst_counter got=%b/%b exp=000/1", rsp_valid_o, r_ready_o); else n_pass++;
        r_valid_i = 1'b0;
        step();
        rstn_i = 1'b1;
        req_valid_i = 3'b111;
        #1;
        n_chk++; if (req_ready_o !== 3'b001) $display("FAIL midrst_ptr got=%b exp=001", req_ready_o); else n_pass++;
        step();
        req_valid_i = '0;
        n_chk++; if (ar_valid_o !== 1'b1 || ar_id_o !== 4'd0) $display("FAIL midrst_first_ar got=%b/%0d exp=1/0", ar_valid_o, ar_id_o); else n_pass++;
        step();
    endtask

    initial begin
        clear_inputs();
        rstn_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_limit();
        test_stall();
        test_unexpected();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
